// File: rtl/alu_exec.sv
// Handshaked ALU: AND/OR/ADD/SUB complete in one cycle, and the result is held until it is consumed.
// Defining ALU_EXEC_SHIFT_EN adds SLL/SRL, which shift one bit per cycle.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

`ifdef ALU_EXEC_SHIFT_EN
  localparam int         SHW     = $clog2(WIDTH);
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [WIDTH-1:0] w_res;

`ifdef ALU_EXEC_SHIFT_EN
  logic [SHW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_left;
  logic [SHW-1:0]   w_shamt;
  logic             w_is_shift;
  logic [WIDTH-1:0] w_shifted;

  assign w_shamt    = b[SHW-1:0];
  assign w_is_shift = (operation == OP_SLL) || (operation == OP_SRL);
  assign w_shifted  = r_left ? (r_acc << 1) : (r_acc >> 1);
`endif

  // Single-cycle result, computed straight from the operands at acceptance.
  always_comb begin
    w_res = '0;
    case (operation)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD:  w_res = a + b;
      OP_SUB:  w_res = a - b;
`ifdef ALU_EXEC_SHIFT_EN
      OP_SLL,
      OP_SRL:  w_res = a;
`endif
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef ALU_EXEC_SHIFT_EN
      r_cnt       <= '0;
      r_acc       <= '0;
      r_left      <= 1'b0;
`endif
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
`ifdef ALU_EXEC_SHIFT_EN
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
            if (w_is_shift && (w_shamt != '0)) begin
              r_state <= SHIFT;
              r_cnt   <= w_shamt;
              r_acc   <= a;
              r_left  <= (operation == OP_SLL);
            end else
`endif
            begin
              r_state     <= DONE;
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_out_valid <= 1'b1;
            end
          end
        end
`ifdef ALU_EXEC_SHIFT_EN
        // The last shift goes directly into result, so DONE begins in the cycle the count reaches zero.
        SHIFT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state     <= DONE;
            r_result    <= w_shifted;
            r_zero      <= (w_shifted == '0);
            r_out_valid <= 1'b1;
          end else begin
            r_acc <= w_shifted;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width in bits; power of two, >= 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port: in_valid  input  1  operands and operation presented.
REQ-006 SHALL have port: in_ready  output  1  block accepts a new operation this cycle.
REQ-007 SHALL have port: operation  input  4  ALU operation code from the ALU control decoder.
REQ-008 SHALL have port: a  input  WIDTH  first operand.
REQ-009 SHALL have port: b  input  WIDTH  second operand; low log2(WIDTH) bits are the shift amount for shifts.
REQ-010 SHALL have port: out_valid  output  1  result and zero are valid.
REQ-011 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have port: result  output  WIDTH  registered ALU result.
REQ-013 SHALL have port: zero  output  1  registered flag, 1 when result == 0.

Function
REQ-014 SHALL implement states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-015 SHALL accept on in_valid & in_ready; a, b, operation are captured at acceptance and later input changes are ignored.
REQ-016 SHALL decode 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; these complete in one cycle: IDLE -> DONE, out_valid high the cycle after acceptance.
REQ-017 SHALL wrap ADD/SUB modulo 2^WIDTH; no carry/overflow output.
REQ-018 SHALL produce result 0, zero 1, one-cycle latency for any undecoded operation code.
REQ-019 SHALL hold result and zero stable in DONE until out_valid & out_ready, then return to IDLE the next cycle.
REQ-020 SHALL not accept a new operation in the cycle DONE is left (in_ready low in DONE); max throughput one op per 2 cycles.
REQ-021 SHALL, on flush, go to IDLE next cycle with out_valid 0, discarding any in-flight or unconsumed result; flush has priority over in_valid and out_ready in the same cycle.
REQ-022 SHALL compute zero from the same value written into result, updated in the same cycle.

Reset
REQ-023 SHALL, while rst is high at a clock edge, set state IDLE, result 0, zero 0, shift counter 0, out_valid 0; in_ready reads 1 the cycle after rst deasserts.
REQ-024 SHALL give rst priority over flush and all handshakes, including mid-SHIFT and in DONE.

Configuration
REQ-025 SHALL, with macro ALU_EXEC_SHIFT_EN defined, decode 0011 SLL and 0100 SRL (logical, zero fill) as iterative shifts by one bit per cycle.
REQ-026 SHALL, for shifts, go IDLE -> SHIFT with counter = shamt, shift one bit and decrement each SHIFT cycle, enter DONE when counter reaches 0; out_valid rises shamt+1 cycles after acceptance.
REQ-027 SHALL, for shamt = 0, go IDLE -> DONE directly with result = a (latency 1).
REQ-028 SHALL, without ALU_EXEC_SHIFT_EN, contain no SHIFT state or counter logic and treat 0011/0100 as undecoded per REQ-018.

Verification
REQ-029 SHALL test ADD: a=0xFFFFFFFF, b=0x00000001, op 0010, out_ready=1 -> next cycle out_valid=1, result=0x00000000, zero=1.
REQ-030 SHALL test SUB with backpressure: a=5, b=7, op 0110, out_ready=0 for 3 cycles -> result=0xFFFFFFFE, zero=0, held stable and in_ready=0 until out_ready=1, then IDLE.
REQ-031 SHALL test AND/OR back-to-back: a=0xF0F0F0F0, b=0xFF00FF00, op 0000 then 0001 -> results 0xF000F000 then 0xFFF0FFF0, second accepted no earlier than 2 cycles after the first.
REQ-032 SHALL test (ALU_EXEC_SHIFT_EN) SLL: a=0x00000001, b=31, op 0011 -> out_valid exactly 32 cycles after acceptance, result=0x80000000; SRL a=0x80000000, b=0 -> result=0x80000000 after 1 cycle.
REQ-033 SHALL test flush/reset mid-operation: SLL b=10 with flush asserted 4 cycles after acceptance -> out_valid never rises, in_ready=1 next cycle; repeat with rst -> result=0, zero=0.
REQ-034 SHALL test undecoded op 1111 (and 0011 without ALU_EXEC_SHIFT_EN): a=3, b=4 -> result=0, zero=1, latency 1.
